// File: rtl/pixel_stream_pkg.sv
// Shared constants and burst FSM encoding for the pixel burst buffer.
package pixel_stream_pkg;

    localparam int unsigned DefaultDataWidth   = 48;
    localparam int unsigned DefaultDepthBits   = 14;
    localparam int unsigned DefaultBurstLen    = 128;
    localparam int unsigned DefaultAfullMargin = 84;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } burst_state_e;

endpackage

// File: rtl/pixel_sync_fifo.sv
// First-word-fall-through synchronous FIFO; the head word is always on rdata_o.
module pixel_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned DEPTH_BITS = 14
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [DEPTH_BITS:0]   data_count_o
);

    localparam int unsigned Depth = 1 << DEPTH_BITS;
    localparam int unsigned CntW  = DEPTH_BITS + 1;

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    // Fullness is judged on the registered count, before any same-cycle pop.
    always_comb begin
        push_ok  = push_i && (count_q != CntW'(Depth));
        pop_ok   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + DEPTH_BITS'(push_ok);
        rd_ptr_d = rd_ptr_q + DEPTH_BITS'(pop_ok);
        count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o      = mem_q[rd_ptr_q];
    assign data_count_o = count_q;

endmodule

// File: rtl/pixel_burst_buffer.sv
// Pixel FIFO feeding an AXI4-Stream master in fixed-length bursts, with flush,
// almost-full and dropped-push accounting.
module pixel_burst_buffer
    import pixel_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefaultDataWidth,
    parameter int unsigned DEPTH_BITS   = DefaultDepthBits,
    parameter int unsigned BURST_LEN    = DefaultBurstLen,
    parameter int unsigned AFULL_MARGIN = DefaultAfullMargin
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_to_fifo,
    input  logic                  fifo_push,
    input  logic                  flush,
    output logic                  fifo_full,
    output logic                  fifo_overflow,
    output logic [15:0]           drop_count,
    output logic [DEPTH_BITS:0]   data_count,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int unsigned         Depth      = 1 << DEPTH_BITS;
    localparam int unsigned         CntW       = DEPTH_BITS + 1;
    localparam logic [DEPTH_BITS:0] DepthCnt   = CntW'(Depth);
    localparam logic [DEPTH_BITS:0] AfullLevel = CntW'(Depth - AFULL_MARGIN);
    localparam logic [DEPTH_BITS:0] BurstCnt   = CntW'(BURST_LEN);

    burst_state_e        state_q, state_d;
    logic [DEPTH_BITS:0] burst_size_q, burst_size_d;
    logic [DEPTH_BITS:0] beat_cnt_q, beat_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                pop, drop, last_beat;

    pixel_sync_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH_BITS(DEPTH_BITS)
    ) u_fifo (
        .clk_i       (aclk),
        .rst_i       (reset),
        .push_i      (fifo_push),
        .wdata_i     (data_to_fifo),
        .pop_i       (pop),
        .rdata_o     (m_axis_tdata),
        .data_count_o(data_count)
    );

    always_comb begin
        state_d      = state_q;
        burst_size_d = burst_size_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;

        last_beat = (beat_cnt_q == burst_size_q - CntW'(1));
        pop       = (state_q == StBurst) && m_axis_tready;
        drop      = fifo_push && (data_count == DepthCnt);

        unique case (state_q)
            StIdle: begin
                if (data_count >= BurstCnt) begin
                    state_d      = StBurst;
                    burst_size_d = BurstCnt;
                end else if (flush_pend_q) begin
                    // Size is frozen here so later pushes wait for the next burst.
                    flush_pend_d = 1'b0;
                    if (data_count != '0) begin
                        state_d      = StBurst;
                        burst_size_d = data_count;
                    end
                end
            end
            StBurst: begin
                if (pop) begin
                    if (last_beat) begin
                        state_d    = StIdle;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // A new request wins over a same-cycle clear so it is not lost.
        if (flush) begin
            flush_pend_d = 1'b1;
        end

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= StIdle;
            burst_size_q <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            burst_size_q <= burst_size_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign m_axis_tvalid = (state_q == StBurst);
    assign m_axis_tlast  = (state_q == StBurst) && last_beat;
    assign fifo_full     = (data_count >= AfullLevel);
    assign fifo_overflow = overflow_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_pixel_burst_buffer.sv
// Scenario bench for pixel_burst_buffer: a default-size instance plus a tiny one
// (16 deep, single-beat bursts) for the almost-full and overflow behaviour.
module tb_pixel_burst_buffer;

    localparam int unsigned DW  = 48;
    localparam int unsigned DB  = 14;
    localparam int unsigned BL  = 128;
    localparam int unsigned SDB = 4;

    logic clk;
    logic reset;

    logic [DW-1:0] din;
    logic          push, flush, full, ovf, tvalid, tready, tlast;
    logic [15:0]   drops;
    logic [DB:0]   count;
    logic [DW-1:0] tdata;

    logic [DW-1:0] s_din;
    logic          s_push, s_flush, s_full, s_ovf, s_tvalid, s_tready, s_tlast;
    logic [15:0]   s_drops;
    logic [SDB:0]  s_count;
    logic [DW-1:0] s_tdata;

    int checks;
    int errors;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    logic          mon_en;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    pixel_burst_buffer dut (
        .aclk         (clk),
        .reset        (reset),
        .data_to_fifo (din),
        .fifo_push    (push),
        .flush        (flush),
        .fifo_full    (full),
        .fifo_overflow(ovf),
        .drop_count   (drops),
        .data_count   (count),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast)
    );

    pixel_burst_buffer #(
        .DATA_WIDTH  (DW),
        .DEPTH_BITS  (SDB),
        .BURST_LEN   (1),
        .AFULL_MARGIN(2)
    ) dut_s (
        .aclk         (clk),
        .reset        (reset),
        .data_to_fifo (s_din),
        .fifo_push    (s_push),
        .flush        (s_flush),
        .fifo_full    (s_full),
        .fifo_overflow(s_ovf),
        .drop_count   (s_drops),
        .data_count   (s_count),
        .m_axis_tdata (s_tdata),
        .m_axis_tvalid(s_tvalid),
        .m_axis_tready(s_tready),
        .m_axis_tlast (s_tlast)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, limit 600000", $time);
        $fatal(1);
    end

    // Beat collector and stall-stability checker for the main instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== prev_data || tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                             tvalid, tdata, tlast, prev_data, prev_last);
                end
            end
            if (tvalid === 1'b1 && tready === 1'b1) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
            end
            prev_stall = (tvalid === 1'b1) && (tready === 1'b0);
            prev_data  = tdata;
            prev_last  = tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [DW-1:0] rnd_word();
        return {16'($urandom), $urandom};
    endfunction

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; push = 1'b0; flush = 1'b0; tready = 1'b0;
        s_push = 1'b0; s_flush = 1'b0; s_tready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete(); got_data.delete(); got_last.delete();
        mon_en = 1'b1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din  = rnd_word();
            push = 1'b1;
            exp_q.push_back(din);
        end
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_beats(input int n, input int limit, input bit rnd_ready, input string tag);
        int cyc;
        cyc = 0;
        while (got_data.size() < n && cyc < limit) begin
            @(posedge clk); #1;
            if (rnd_ready) tready = 1'($urandom_range(0, 1));
            cyc++;
        end
        if (got_data.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: beats=%0d after %0d cycles, required %0d",
                     tag, got_data.size(), limit, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || count !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_main_flags: valid=%b last=%b count=%0d full=%b, required 0 0 0 0",
                     tvalid, tlast, count, full);
        end
        checks++;
        if (ovf !== 1'b0 || drops !== 16'd0) begin
            errors++;
            $display("FAIL reset_main_drop: ovf=%b drops=%0d, required 0 0", ovf, drops);
        end
        checks++;
        if (s_tvalid !== 1'b0 || s_tlast !== 1'b0 || s_count !== '0 || s_full !== 1'b0 ||
            s_ovf !== 1'b0 || s_drops !== 16'd0) begin
            errors++;
            $display("FAIL reset_small: valid=%b last=%b count=%0d full=%b ovf=%b drops=%0d, required all 0",
                     s_tvalid, s_tlast, s_count, s_full, s_ovf, s_drops);
        end
    endtask

    task automatic test_full_burst();
        int nbad;
        do_reset();
        tready = 1'b1;
        push_words(BL);
        checks++;
        if (tvalid !== 1'b0 || int'(count) != BL) begin
            errors++;
            $display("FAIL full_latency_pre: valid=%b count=%0d, required 0 %0d", tvalid, count, BL);
        end
        @(posedge clk); #1;
        checks++;
        if (tvalid !== 1'b1) begin
            errors++;
            $display("FAIL full_latency_rise: valid=%b, required 1", tvalid);
        end
        wait_beats(BL, 400, 1'b0, "full");
        nbad = 0;
        for (int i = 0; i < BL; i++)
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == BL - 1)) nbad++;
        checks++;
        if (nbad != 0 || got_data.size() != BL) begin
            errors++;
            $display("FAIL full_beats: %0d bad of %0d received, required 0 bad of %0d",
                     nbad, got_data.size(), BL);
        end
        checks++;
        if (tvalid !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL full_end: valid=%b count=%0d, required 0 0", tvalid, count);
        end
    endtask

    task automatic test_flush();
        int nbad;
        do_reset();
        tready = 1'b1;
        push_words(40);
        idle_cycles(5);
        checks++;
        if (tvalid !== 1'b0 || count !== 15'd40) begin
            errors++;
            $display("FAIL flush_wait: valid=%b count=%0d, required 0 40", tvalid, count);
        end
        pulse_flush();
        wait_beats(40, 200, 1'b0, "flush");
        nbad = 0;
        for (int i = 0; i < 40; i++)
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == 39)) nbad++;
        checks++;
        if (nbad != 0 || got_data.size() != 40) begin
            errors++;
            $display("FAIL flush_beats: %0d bad of %0d received, required 0 bad of 40",
                     nbad, got_data.size());
        end
        checks++;
        if (count !== '0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: count=%0d valid=%b, required 0 0", count, tvalid);
        end
        push_words(5);
        idle_cycles(10);
        checks++;
        if (tvalid !== 1'b0 || count !== 15'd5) begin
            errors++;
            $display("FAIL flush_pend_clear: valid=%b count=%0d, required 0 5", tvalid, count);
        end
    endtask

    task automatic test_flush_empty();
        do_reset();
        tready = 1'b1;
        pulse_flush();
        idle_cycles(3);
        push_words(5);
        idle_cycles(10);
        checks++;
        if (tvalid !== 1'b0 || count !== 15'd5 || got_data.size() != 0) begin
            errors++;
            $display("FAIL flush_empty: valid=%b count=%0d beats=%0d, required 0 5 0",
                     tvalid, count, got_data.size());
        end
    endtask

    task automatic test_stall();
        int nbad;
        do_reset();
        tready = 1'b0;
        push_words(BL);
        idle_cycles(3);
        checks++;
        if (tvalid !== 1'b1 || tdata !== exp_q[0] || tlast !== 1'b0) begin
            errors++;
            $display("FAIL stall_head: valid=%b data=%h last=%b, required 1 %h 0",
                     tvalid, tdata, tlast, exp_q[0]);
        end
        wait_beats(BL, 3000, 1'b1, "stall");
        tready = 1'b1;
        nbad = 0;
        for (int i = 0; i < BL; i++)
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == BL - 1)) nbad++;
        checks++;
        if (nbad != 0 || got_data.size() != BL) begin
            errors++;
            $display("FAIL stall_beats: %0d bad of %0d received, required 0 bad of %0d",
                     nbad, got_data.size(), BL);
        end
    endtask

    task automatic test_reset_mid_burst();
        int nbad;
        do_reset();
        tready = 1'b1;
        push_words(BL);
        wait_beats(50, 400, 1'b0, "mid");
        reset = 1'b1;
        push  = 1'b1;
        din   = rnd_word();
        @(posedge clk); #1;
        checks++;
        if (tvalid !== 1'b0 || tlast !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL mid_reset_state: valid=%b last=%b count=%0d, required 0 0 0",
                     tvalid, tlast, count);
        end
        push  = 1'b0;
        reset = 1'b0;
        nbad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== exp_q[i] || got_last[i] !== 1'b0) nbad++;
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL mid_partial: %0d bad beats before reset, required 0", nbad);
        end
        exp_q.delete(); got_data.delete(); got_last.delete();
        push_words(BL);
        wait_beats(BL, 400, 1'b0, "mid_refill");
        nbad = 0;
        for (int i = 0; i < BL; i++)
            if (got_data[i] !== exp_q[i] || got_last[i] !== (i == BL - 1)) nbad++;
        checks++;
        if (nbad != 0 || got_data.size() != BL) begin
            errors++;
            $display("FAIL mid_refill_beats: %0d bad of %0d received, required 0 bad of %0d",
                     nbad, got_data.size(), BL);
        end
    endtask

    task automatic test_flush_during_burst();
        int nbad;
        do_reset();
        tready = 1'b0;
        push_words(BL);
        idle_cycles(2);
        push_words(10);
        pulse_flush();
        wait_beats(BL + 10, 4000, 1'b1, "flush_burst");
        tready = 1'b1;
        nbad = 0;
        for (int i = 0; i < BL + 10; i++)
            if (got_data[i] !== exp_q[i] ||
                got_last[i] !== (i == BL - 1 || i == BL + 9)) nbad++;
        checks++;
        if (nbad != 0 || got_data.size() != BL + 10) begin
            errors++;
            $display("FAIL flush_burst_beats: %0d bad of %0d received, required 0 bad of %0d",
                     nbad, got_data.size(), BL + 10);
        end
        idle_cycles(2);
        checks++;
        if (count !== '0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_burst_end: count=%0d valid=%b, required 0 0", count, tvalid);
        end
    endtask

    task automatic test_overflow_small();
        logic [DW-1:0] s_exp[$];
        logic [DW-1:0] s_got[$];
        logic          s_lst[$];
        int            model;
        int            nbad;
        do_reset();
        s_push = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_din = rnd_word();
            if (i < 16) s_exp.push_back(s_din);
            @(posedge clk); #1;
            model = (i + 1 < 16) ? i + 1 : 16;
            checks++;
            if (int'(s_count) != model || s_full !== (model >= 14)) begin
                errors++;
                $display("FAIL small_fill_%0d: count=%0d full=%b, required %0d %b",
                         i, s_count, s_full, model, (model >= 14));
            end
        end
        s_push = 1'b0;
        checks++;
        if (s_ovf !== 1'b1 || s_drops !== 16'd4) begin
            errors++;
            $display("FAIL small_drops: ovf=%b drops=%0d, required 1 4", s_ovf, s_drops);
        end
        s_tready = 1'b1;
        for (int c = 0; c < 200 && s_got.size() < 16; c++) begin
            @(negedge clk);
            if (s_tvalid === 1'b1) begin
                s_got.push_back(s_tdata);
                s_lst.push_back(s_tlast);
            end
        end
        idle_cycles(3);
        nbad = 0;
        for (int i = 0; i < 16; i++)
            if (s_got[i] !== s_exp[i] || s_lst[i] !== 1'b1) nbad++;
        checks++;
        if (nbad != 0 || s_got.size() != 16) begin
            errors++;
            $display("FAIL small_single_beats: %0d bad of %0d received, required 0 bad of 16",
                     nbad, s_got.size());
        end
        checks++;
        if (s_count !== '0 || s_full !== 1'b0 || s_ovf !== 1'b1 || s_drops !== 16'd4) begin
            errors++;
            $display("FAIL small_after_drain: count=%0d full=%b ovf=%b drops=%0d, required 0 0 1 4",
                     s_count, s_full, s_ovf, s_drops);
        end
    endtask

    initial begin
        checks = 0; errors = 0; mon_en = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        reset = 1'b1; din = '0; push = 1'b0; flush = 1'b0; tready = 1'b0;
        s_din = '0; s_push = 1'b0; s_flush = 1'b0; s_tready = 1'b0;
        test_reset();
        test_full_burst();
        test_flush();
        test_flush_empty();
        test_stall();
        test_reset_mid_burst();
        test_flush_during_burst();
        test_overflow_small();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_burst_buffer.md
PIXEL_BURST_BUFFER -- requirements
Module: pixel_burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 48, pixel word width in bits.
REQ-002 SHALL have parameter DEPTH_BITS, default 14; FIFO depth DEPTH = 2**DEPTH_BITS words.
REQ-003 SHALL have parameter BURST_LEN, default 128, beats per full burst; legal range 1..DEPTH.
REQ-004 SHALL have parameter AFULL_MARGIN, default 84; the almost-full threshold is DEPTH-AFULL_MARGIN.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 aclk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_to_fifo  input  DATA_WIDTH  pixel word to store.
REQ-009 fifo_push  input  1  write strobe for data_to_fifo.
REQ-010 flush  input  1  single-cycle request to drain a partial burst.
REQ-011 fifo_full  output  1  almost-full flag for the upstream producer.
REQ-012 fifo_overflow  output  1  sticky flag, set when a push is dropped.
REQ-013 drop_count  output  16  saturating count of dropped pushes.
REQ-014 data_count  output  DEPTH_BITS+1  current FIFO occupancy.
REQ-015 m_axis_tdata / m_axis_tvalid / m_axis_tready / m_axis_tlast  out/out/in/out  DATA_WIDTH/1/1/1  AXI4-Stream master.

Function
REQ-016 A push SHALL be accepted iff fifo_push=1 and data_count<DEPTH, judged before any same-cycle pop.
REQ-017 A push at data_count==DEPTH SHALL be dropped, set fifo_overflow, and increment drop_count, which saturates at 16'hFFFF.
REQ-018 A beat SHALL be popped iff m_axis_tvalid && m_axis_tready; an accepted push and a pop in the same cycle SHALL leave data_count unchanged.
REQ-019 fifo_full SHALL be combinational: data_count >= DEPTH-AFULL_MARGIN.
REQ-020 The FIFO SHALL be first-word-fall-through: m_axis_tdata shows the head word whenever m_axis_tvalid=1.
REQ-021 FSM states SHALL be IDLE and BURST.
REQ-022 IDLE->BURST: when data_count>=BURST_LEN, the burst size SHALL latch as BURST_LEN.
REQ-023 IDLE->BURST: otherwise, when flush_pend=1 and data_count>0, the burst size SHALL latch as data_count and flush_pend SHALL clear.
REQ-024 In IDLE with flush_pend=1 and data_count==0, flush_pend SHALL clear with no burst.
REQ-025 The m_axis_tvalid register SHALL be 1 exactly while in BURST; it rises on the cycle after the IDLE condition is met (1-cycle latency).
REQ-026 While tvalid=1 and tready=0, tdata, tvalid and tlast SHALL hold stable.
REQ-027 A beat counter SHALL count accepted beats; tlast SHALL be 1 on beat burst_size-1 only.
REQ-028 Acceptance of the tlast beat SHALL return the FSM to IDLE, with tvalid=0 the next cycle (at least one idle cycle between bursts).
REQ-029 A flush pulse SHALL set flush_pend in any state; a flush during BURST is served after that burst completes.
REQ-030 Words pushed after a flush burst size is latched SHALL NOT join that burst.
REQ-031 With BURST_LEN==1, every burst SHALL be one beat with tlast=1.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL empty the FIFO, enter IDLE and clear flush_pend, the beat counter, fifo_overflow and drop_count.
REQ-033 After that edge, m_axis_tvalid, m_axis_tlast and data_count SHALL be 0, and fifo_full SHALL be 0.
REQ-034 Reset asserted mid-burst SHALL abort the burst, with no partial tlast emitted; pushes during reset SHALL be ignored.

Structure
REQ-035 Package pixel_stream_pkg SHALL hold the FSM state encoding and the default parameter constants.
REQ-036 Storage SHALL be a single sub-module, pixel_sync_fifo: FWFT, parametrised by DATA_WIDTH and DEPTH_BITS, with a data_count output.
REQ-037 pixel_burst_buffer SHALL contain the burst FSM, flush logic, drop counter and flags.

Verification
REQ-038 Push 128 words, tready=1 -> tvalid rises 1 cycle after count hits 128, 128 consecutive beats in order, tlast on beat 127 only.
REQ-039 Push 40 words, pulse flush -> one 40-beat burst with tlast on beat 39; data_count=0 afterwards; flush_pend clear.
REQ-040 Full burst with tready toggled pseudo-randomly -> tdata/tlast stable during every stall; no beat lost or duplicated.
REQ-041 DEPTH_BITS=4, AFULL_MARGIN=2, sink stalled, 20 pushes -> fifo_full at count 14, 4 drops, fifo_overflow=1, drop_count=4.
REQ-042 Reset asserted at beat 50 of a 128-beat burst -> tvalid=0, data_count=0 next cycle; a fresh 128-word fill yields a normal burst.
REQ-043 Flush pulse during BURST with 10 extra words stored -> current burst ends normally, then a 10-beat burst with tlast on beat 9.
